register_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single register bank between NUM_REQ requesters, such as the control unit, the ALU writeback and the debug port. It grants one request at a time, drives the bank's write port (Rx path) or bus-read port (Ry path), and captures bus read data. It returns a per-requester completion pulse. It sits between the requesters and register_bank; it is the only driver of the bank's control inputs.

---
 rtl/register_bank_pkg.sv | 25 ++
 rtl/rr_priority_picker.sv | 44 ++++
 rtl/register_bank_arbiter.sv | 149 ++++++++++++++
 tb/tb_register_bank_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
// Shared definitions for the register bank arbiter slice.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default bank geometry (8 x 8-bit registers)
//   arb_state_t                     : arbiter sequencer state encoding
//   op_t                            : requester operation encoding
// -----------------------------------------------------------------------------
package register_bank_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin pick: the winner is the first set request bit
// found scanning upward from (last_winner + 1) mod NUM_REQ, wrapping around.
// Ports:
//   req         in  NUM_REQ  request vector
//   last_winner in  IDX_W    index granted most recently
//   winner_oh   out NUM_REQ  one-hot winner (all zero when no request)
//   winner_idx  out IDX_W    binary winner index (0 when no request)
//   any_req     out 1        at least one request bit set
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    // i runs 1..NUM_REQ so the last winner itself is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_winner) + 32'(i)) % 32'(NUM_REQ));
      if (!found && req[cand]) begin
        found             = 1'b1;
        winner_oh[cand]   = 1'b1;
        winner_idx        = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/register_bank_arbiter.sv
// -----------------------------------------------------------------------------
// register_bank_arbiter
// Shares one register bank between NUM_REQ requesters. One transaction is in
// flight at a time: IDLE picks a winner round-robin and latches its request,
// ISSUE drives the bank write port (Rx) or bus-read port (Ry), CAPTURE
// registers the bus read data, RESP pulses the winner's completion.
//
// Handshake: a requester raises in_req[i] with op/addr/data and holds all of
// them stable until it sees out_gnt[i] (a one-cycle pulse); it drops in_req[i]
// in that grant cycle for a single transaction. A request still high when the
// arbiter returns to IDLE is a new request. out_rsp_valid[i] pulses once per
// completed transaction; out_rsp_data is meaningful during that pulse for reads.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_req/_write/_addr/_data   per-requester request (packed, requester i at
//                       [i*W +: W])
//   out_gnt             one-hot grant pulse
//   out_rsp_valid       one-hot completion pulse
//   out_rsp_data        captured read data (holds between reads)
//   out_rb_*            bank control: write_en, read_en, rx/ry selectors, data
//   in_rb_bus_data      bank bus read data
//   dbg_state           current sequencer state (arb_state_t encoding)
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module register_bank_arbiter
  import register_bank_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             in_req,
  input  logic [NUM_REQ-1:0]             in_req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  in_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_req_data,
  output logic [NUM_REQ-1:0]             out_gnt,
  output logic [NUM_REQ-1:0]             out_rsp_valid,
  output logic [DATA_WIDTH-1:0]          out_rsp_data,
  output logic                           out_rb_write_en,
  output logic                           out_rb_read_en,
  output logic [ADDR_WIDTH-1:0]          out_rb_rx_selector,
  output logic [ADDR_WIDTH-1:0]          out_rb_ry_selector,
  output logic [DATA_WIDTH-1:0]          out_rb_data,
  input  logic [DATA_WIDTH-1:0]          in_rb_bus_data,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       last_winner_q;
  logic [NUM_REQ-1:0]     winner_oh_q;
  op_t                    op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  rsp_data_q;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   any_req;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req         (in_req),
    .last_winner (last_winner_q),
    .winner_oh   (pick_oh),
    .winner_idx  (pick_idx),
    .any_req     (any_req)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = (op_q == OP_WRITE) ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset points last_winner at the top index
  // so the scan starts at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      winner_oh_q   <= '0;
      op_q          <= OP_READ;
      addr_q        <= '0;
      data_q        <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        last_winner_q <= pick_idx;
        winner_oh_q   <= pick_oh;
        op_q          <= op_t'(in_req_write[pick_idx]);
        addr_q        <= in_req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        data_q        <= in_req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_q == CAPTURE) begin
        rsp_data_q <= in_rb_bus_data;
      end
    end
  end

  // Output decode from registered state; everything idles at zero.
  always_comb begin
    out_gnt            = '0;
    out_rsp_valid      = '0;
    out_rb_write_en    = 1'b0;
    out_rb_read_en     = 1'b0;
    out_rb_rx_selector = '0;
    out_rb_ry_selector = '0;
    out_rb_data        = '0;
    case (state_q)
      ISSUE: begin
        out_gnt = winner_oh_q;
        if (op_q == OP_WRITE) begin
          out_rb_write_en    = 1'b1;
          out_rb_rx_selector = addr_q;
          out_rb_data        = data_q;
        end else begin
          out_rb_read_en     = 1'b1;
          out_rb_ry_selector = addr_q;
        end
      end
      CAPTURE: begin
        out_rb_read_en     = 1'b1;
        out_rb_ry_selector = addr_q;
      end
      RESP: begin
        out_rsp_valid = winner_oh_q;
      end
      default: ;
    endcase
  end

  assign out_rsp_data = rsp_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_register_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_bank_arbiter
// Directed bench for register_bank_arbiter with a behavioural register bank,
// a reference memory for expected read data and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_register_bank_arbiter;
  import register_bank_pkg::*;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- DUT ----------------
  logic [NR-1:0]    in_req, in_req_write;
  logic [NR*AW-1:0] in_req_addr;
  logic [NR*DW-1:0] in_req_data;
  logic [NR-1:0]    out_gnt, out_rsp_valid;
  logic [DW-1:0]    out_rsp_data, out_rb_data, in_rb_bus_data;
  logic             out_rb_write_en, out_rb_read_en;
  logic [AW-1:0]    out_rb_rx_selector, out_rb_ry_selector;
  logic [1:0]       dbg_state;

  register_bank_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_req             (in_req),
    .in_req_write       (in_req_write),
    .in_req_addr        (in_req_addr),
    .in_req_data        (in_req_data),
    .out_gnt            (out_gnt),
    .out_rsp_valid      (out_rsp_valid),
    .out_rsp_data       (out_rsp_data),
    .out_rb_write_en    (out_rb_write_en),
    .out_rb_read_en     (out_rb_read_en),
    .out_rb_rx_selector (out_rb_rx_selector),
    .out_rb_ry_selector (out_rb_ry_selector),
    .out_rb_data        (out_rb_data),
    .in_rb_bus_data     (in_rb_bus_data),
    .dbg_state          (dbg_state)
  );

  // ---------------- bank model ----------------
  logic [DW-1:0] bank [8];
  logic          bank_init;
  logic          bus_ovr_en;
  logic [DW-1:0] bus_ovr;

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (out_rb_write_en) begin
      bank[out_rb_rx_selector] <= out_rb_data;
    end
  end

  assign in_rb_bus_data = bus_ovr_en ? bus_ovr : bank[out_rb_ry_selector];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: [11]=write, [10:8]=one-hot requester, [7:0]=read data.
  logic [11:0]   exp_q[$];
  logic [11:0]   item;
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] model_rsp_data = '0;

  always @(negedge clk) begin
    if (rst) model_rsp_data = '0;
    if (out_rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(out_rsp_valid), 32'd0);
      end else begin
        item = exp_q.pop_front();
        check("rsp_valid", 32'(out_rsp_valid), 32'(item[10:8]));
        if (item[11] == 1'b0) begin
          check("rsp_rd_data", 32'(out_rsp_data), 32'(item[7:0]));
          model_rsp_data = item[7:0];
        end else begin
          check("rsp_wr_data_hold", 32'(out_rsp_data), 32'(model_rsp_data));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int last_gnt_cycle = 0;

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    in_req[idx]                = 1'b1;
    in_req_write[idx]          = wr;
    in_req_addr[idx*AW +: AW]  = a;
    in_req_data[idx*DW +: DW]  = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},     32'(out_gnt), 32'd0);
    check({tag, "_rsp_v"},   32'(out_rsp_valid), 32'd0);
    check({tag, "_wr_en"},   32'(out_rb_write_en), 32'd0);
    check({tag, "_rd_en"},   32'(out_rb_read_en), 32'd0);
    check({tag, "_rx_sel"},  32'(out_rb_rx_selector), 32'd0);
    check({tag, "_ry_sel"},  32'(out_rb_ry_selector), 32'd0);
    check({tag, "_rb_data"}, 32'(out_rb_data), 32'd0);
    check({tag, "_state"},   32'(dbg_state), 32'(IDLE));
  endtask

  // Returns in the negedge of the grant cycle (bounded wait).
  task automatic wait_gnt(input int idx);
    int waited = 0;
    logic [NR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    @(negedge clk);
    while (out_gnt === '0 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    check("gnt", 32'(out_gnt), 32'(oh));
    last_gnt_cycle = cycle;
  endtask

  // Full transaction for requester idx using its currently driven fields.
  task automatic run_txn(input int idx, input bit drop);
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NR-1:0] oh;
    wr = in_req_write[idx];
    a  = in_req_addr[idx*AW +: AW];
    d  = in_req_data[idx*DW +: DW];
    oh = '0;
    oh[idx] = 1'b1;
    if (wr) begin
      exp_q.push_back({1'b1, oh, 8'h00});
      ref_mem[a] = d;
    end else begin
      exp_q.push_back({1'b0, oh, ref_mem[a]});
    end
    wait_gnt(idx);
    if (drop) in_req[idx] = 1'b0;
    check("issue_state", 32'(dbg_state), 32'(ISSUE));
    if (wr) begin
      check("wr_en",     32'(out_rb_write_en), 32'd1);
      check("wr_rx_sel", 32'(out_rb_rx_selector), 32'(a));
      check("wr_data",   32'(out_rb_data), 32'(d));
      check("wr_rd_en",  32'(out_rb_read_en), 32'd0);
    end else begin
      check("rd_en_issue",  32'(out_rb_read_en), 32'd1);
      check("rd_ry_issue",  32'(out_rb_ry_selector), 32'(a));
      check("rd_wr_en",     32'(out_rb_write_en), 32'd0);
      @(negedge clk);
      check("cap_state",    32'(dbg_state), 32'(CAPTURE));
      check("rd_en_cap",    32'(out_rb_read_en), 32'd1);
      check("rd_ry_cap",    32'(out_rb_ry_selector), 32'(a));
      check("cap_gnt",      32'(out_gnt), 32'd0);
    end
    @(negedge clk);
    check("resp_state",  32'(dbg_state), 32'(RESP));
    check("resp_wr_en",  32'(out_rb_write_en), 32'd0);
    check("resp_rd_en",  32'(out_rb_read_en), 32'd0);
    check("resp_gnt",    32'(out_gnt), 32'd0);
    check("resp_ry_sel", 32'(out_rb_ry_selector), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g [4];
    rst          = 1'b1;
    bank_init    = 1'b1;
    bus_ovr_en   = 1'b0;
    bus_ovr      = '0;
    in_req       = 3'($urandom_range(0, 7));
    in_req_write = 3'($urandom_range(0, 7));
    in_req_addr  = 9'($urandom_range(0, 511));
    in_req_data  = 24'($urandom);
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    // Test 1: reset with random requests, then RR starts at requester 0.
    repeat (2) begin
      @(negedge clk);
      check_idle("rst");
      check("rst_rsp_data", 32'(out_rsp_data), 32'd0);
      in_req = 3'($urandom_range(0, 7));
    end
    rst       = 1'b0;
    bank_init = 1'b0;
    in_req    = '0;
    @(negedge clk);
    check_idle("post_rst");
    set_req(1, 1'b0, 3'd5, 8'h00);
    set_req(2, 1'b1, 3'd6, 8'h66);
    run_txn(1, 1'b1);
    run_txn(2, 1'b1);

    // Test 2: requester 0 writes R4 = AA.
    set_req(0, 1'b1, 3'd4, 8'hAA);
    run_txn(0, 1'b1);
    check("bank_r4", 32'(bank[4]), 32'h0000_00AA);
    check("bank_r6", 32'(bank[6]), 32'h0000_0066);

    // Test 3: requester 1 reads R4, then requester 2 reads R0.
    set_req(1, 1'b0, 3'd4, 8'h00);
    run_txn(1, 1'b1);
    set_req(2, 1'b0, 3'd0, 8'h00);
    run_txn(2, 1'b1);

    // Test 4: all three held -> grants 0,1,2,0 spaced three cycles.
    set_req(0, 1'b1, 3'd0, 8'h10);
    set_req(1, 1'b1, 3'd1, 8'h21);
    set_req(2, 1'b1, 3'd2, 8'h32);
    for (int k = 0; k < 4; k++) begin
      run_txn(k % 3, 1'b0);
      g[k] = last_gnt_cycle;
    end
    in_req = '0;
    for (int k = 1; k < 4; k++) check("gnt_spacing", 32'(g[k] - g[k-1]), 32'd3);
    check("bank_r1", 32'(bank[1]), 32'h0000_0021);
    check("bank_r2", 32'(bank[2]), 32'h0000_0032);

    // Test 5: write R0 = FF then read it back; idle bus changes are ignored.
    set_req(0, 1'b1, 3'd0, 8'hFF);
    run_txn(0, 1'b1);
    set_req(2, 1'b0, 3'd0, 8'h00);
    run_txn(2, 1'b1);
    bus_ovr_en = 1'b1;
    bus_ovr    = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("idle_rd_en",    32'(out_rb_read_en), 32'd0);
      check("idle_rsp_data", 32'(out_rsp_data), 32'h0000_00FF);
    end
    bus_ovr_en = 1'b0;

    // Test 6: reset during CAPTURE drops the read.
    set_req(1, 1'b0, 3'd1, 8'h00);
    wait_gnt(1);
    in_req[1] = 1'b0;
    @(negedge clk);
    check("t6_cap_state", 32'(dbg_state), 32'(CAPTURE));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t6_rst");
    check("t6_rsp_data", 32'(out_rsp_data), 32'd0);
    @(negedge clk);
    check_idle("t6_after");

    // Reset in the ISSUE cycle of a write: the write still lands in the bank.
    set_req(1, 1'b1, 3'd7, 8'h77);
    wait_gnt(1);
    in_req[1] = 1'b0;
    check("t6w_wr_en", 32'(out_rb_write_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[7] = 8'h77;
    check_idle("t6w_rst");
    check("t6w_bank_r7", 32'(bank[7]), 32'h0000_0077);
    repeat (2) @(negedge clk);

    // Served normally afterwards.
    set_req(2, 1'b1, 3'd3, 8'hC3);
    run_txn(2, 1'b1);
    set_req(0, 1'b0, 3'd3, 8'h00);
    run_txn(0, 1'b1);
    set_req(1, 1'b0, 3'd7, 8'h00);
    run_txn(1, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: stop the run if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule
